// File: rtl/kgp_multicycle_core.sv
// Multicycle KGP-RISC core: a register-file datapath sequenced by a
// FETCH/DECODE/EXEC/MEM/WB/HALT control FSM. Instruction and data memories
// sit behind req/ready handshakes, so any number of wait states is tolerated.
module kgp_multicycle_core #(
    parameter int                XLEN     = 32,
    parameter int                NREG     = 32,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);
    localparam int RI  = $clog2(NREG);
    localparam int SHW = $clog2(XLEN);

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_I    = 6'd1;
    localparam logic [5:0] OP_LW   = 6'd2;
    localparam logic [5:0] OP_SW   = 6'd3;
    localparam logic [5:0] OP_BR   = 6'd4;
    localparam logic [5:0] OP_J    = 6'd5;
    localparam logic [5:0] OP_HALT = 6'd63;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc_r, npc;
    logic [31:0]       ir;
    logic [XLEN-1:0]   a_r, b_r, imm_r, aluout, lmd;
    logic [XLEN-1:0]   rf [NREG];
    logic              illegal_r;

    // Instruction fields; register indices use only the low log2(NREG) bits.
    logic [5:0]        op;
    logic [RI-1:0]     rs_i, rt_i, rd_i, wb_dst;
    logic [3:0]        funct;
    logic [4:0]        cond;
    logic              decode_bad, br_taken;
    logic [XLEN-1:0]   exec_res, wb_val;
    logic [ADDR_W-1:0] br_tgt, j_tgt;

    assign op     = ir[31:26];
    assign rs_i   = ir[21 +: RI];
    assign rt_i   = ir[16 +: RI];
    assign rd_i   = ir[11 +: RI];
    assign funct  = ir[3:0];
    assign cond   = ir[20:16];
    assign wb_dst = (op == OP_R) ? rd_i : rt_i;
    assign wb_val = (op == OP_LW) ? lmd : aluout;

    // Offsets are word counts; shift by 2, sign-extend, then wrap to ADDR_W.
    assign br_tgt = npc + ADDR_W'($signed({ir[15:0], 2'b00}));
    assign j_tgt  = npc + ADDR_W'($signed({ir[25:0], 2'b00}));

    assign imem_addr  = pc_r;
    assign pc         = pc_r;
    assign dmem_addr  = ADDR_W'(aluout);
    assign dmem_wdata = b_r;

    function automatic logic [XLEN-1:0] alu(input logic [XLEN-1:0] x,
                                            input logic [XLEN-1:0] y,
                                            input logic [3:0]      f);
        logic signed [XLEN-1:0] xs;
        logic signed [XLEN-1:0] ys;
        logic [SHW-1:0]         sh;
        xs = signed'(x);
        ys = signed'(y);
        sh = y[SHW-1:0];
        case (f)
            4'd0:    alu = x + y;
            4'd1:    alu = x - y;
            4'd2:    alu = x & y;
            4'd3:    alu = x | y;
            4'd4:    alu = x ^ y;
            4'd5:    alu = x << sh;
            4'd6:    alu = x >> sh;
            4'd7:    alu = xs >>> sh;
            4'd8:    alu = {{(XLEN-1){1'b0}}, (xs < ys)};
            default: alu = '0;
        endcase
    endfunction

    // Flag undefined opcodes, R-type functs above slt and branch conditions above 3.
    always_comb begin
        decode_bad = 1'b0;
        case (op)
            OP_R:                            decode_bad = (funct > 4'd8);
            OP_BR:                           decode_bad = (cond > 5'd3);
            OP_I, OP_LW, OP_SW, OP_J, OP_HALT: decode_bad = 1'b0;
            default:                         decode_bad = 1'b1;
        endcase
    end

    // EXEC result (R-type uses funct, everything else is A + IMM) and branch decision.
    always_comb begin
        exec_res = (op == OP_R) ? alu(a_r, b_r, funct) : (a_r + imm_r);
        case (cond)
            5'd0:    br_taken = (a_r == '0);
            5'd1:    br_taken = (a_r != '0);
            5'd2:    br_taken = a_r[XLEN-1];
            5'd3:    br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nx;
    end

    // Next-state sequencing; HALT is absorbing.
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  if (imem_ready) state_nx = S_DECODE;
            S_DECODE: state_nx = (decode_bad || op == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_BR, OP_J:  state_nx = S_FETCH;
                    OP_LW, OP_SW: state_nx = S_MEM;
                    default:      state_nx = S_WB;
                endcase
            end
            S_MEM:    if (dmem_ready) state_nx = (op == OP_LW) ? S_WB : S_FETCH;
            S_WB:     state_nx = S_FETCH;
            default:  state_nx = S_HALT;
        endcase
    end

    // Handshake and status outputs; forced low while reset is asserted.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        if (!reset) begin
            illegal = illegal_r;
            case (state)
                S_FETCH: imem_req = 1'b1;
                S_EXEC:  retire   = (op == OP_BR) || (op == OP_J);
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (op == OP_SW);
                    retire   = (op == OP_SW) && dmem_ready;
                end
                S_WB:    retire   = 1'b1;
                S_HALT:  halted   = 1'b1;
                default: ;
            endcase
        end
    end

    // Datapath registers: each is loaded only in the state that owns it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r   <= RESET_PC;
            npc    <= '0;
            ir     <= '0;
            a_r    <= '0;
            b_r    <= '0;
            imm_r  <= '0;
            aluout <= '0;
            lmd    <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir  <= imem_rdata;
                        npc <= pc_r + ADDR_W'(4);
                    end
                end
                S_DECODE: begin
                    a_r   <= rf[rs_i];
                    b_r   <= rf[rt_i];
                    imm_r <= XLEN'($signed(ir[15:0]));
                end
                S_EXEC: begin
                    aluout <= exec_res;
                    if (op == OP_BR)     pc_r <= br_taken ? br_tgt : npc;
                    else if (op == OP_J) pc_r <= j_tgt;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (op == OP_LW) lmd  <= dmem_rdata;
                        else             pc_r <= npc;
                    end
                end
                S_WB:    pc_r <= npc;
                default: ;
            endcase
        end
    end

    // Register file: single write port in WB; r0 is never written so it reads 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (state == S_WB && wb_dst != '0) begin
            rf[wb_dst] <= wb_val;
        end
    end

    // Sticky record that the halt came from an undefined encoding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                illegal_r <= 1'b0;
        else if (state == S_DECODE && decode_bad) illegal_r <= 1'b1;
    end

endmodule

// File: tb/tb_kgp_multicycle_core.sv
// Bench for kgp_multicycle_core: behavioural instruction/data memories with
// programmable wait states, small programs, and a store scoreboard.
module tb_kgp_multicycle_core;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int ADDR_W = 16;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata = '0;
    logic              imem_ready = 1'b0;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [XLEN-1:0]   dmem_rdata = '0;
    logic              dmem_ready = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic              retire;
    logic              halted;
    logic              illegal;

    kgp_multicycle_core #(.XLEN(XLEN), .NREG(NREG), .ADDR_W(ADDR_W), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .pc(pc), .retire(retire), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        int          cnt;
        bit          stable;
    } st_t;

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];
    int iwait = 0;
    int dwait = 0;
    int icnt = 0;
    int dcnt = 0;
    int checks = 0;
    int errors = 0;

    int          ret_cyc[$];
    logic [15:0] rpc_q[$];
    logic [15:0] fetch_q[$];
    st_t         act_q[$];
    st_t         exp_q[$];
    bit          timeout;
    int          halt_reqs;

    // Instruction memory: answers imem_req after iwait wait cycles.
    initial forever begin
        @(posedge clk); #2;
        if (reset || !imem_req) begin
            imem_ready = 1'b0; icnt = 0;
        end else if (icnt >= iwait) begin
            imem_ready = 1'b1; imem_rdata = imem[imem_addr[9:2]]; icnt = 0;
        end else begin
            imem_ready = 1'b0; icnt++;
        end
    end

    // Data memory: answers dmem_req after dwait wait cycles.
    initial forever begin
        @(posedge clk); #2;
        if (reset || !dmem_req) begin
            dmem_ready = 1'b0; dcnt = 0;
        end else if (dcnt >= dwait) begin
            dmem_ready = 1'b1; dcnt = 0;
            if (dmem_we) dmem[dmem_addr[9:2]] = dmem_wdata;
            else         dmem_rdata = dmem[dmem_addr[9:2]];
        end else begin
            dmem_ready = 1'b0; dcnt++;
        end
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input int f);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 7'd0, 4'(f)};
    endfunction

    function automatic st_t mk_st(input logic [15:0] a, input logic [31:0] d, input int c);
        st_t s;
        s.addr = a; s.data = d; s.cnt = c; s.stable = 1'b1;
        return s;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = HALT_W;
            dmem[i] = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        ret_cyc.delete(); rpc_q.delete(); fetch_q.delete(); act_q.delete();
        reset = 1'b0;
    endtask

    // Runs until halted (or budget), recording retires, pc after each retire,
    // completed fetch addresses and completed stores; then watches HALT a while.
    task automatic run_prog(input int budget);
        int  cyc = 0;
        bit  last_ret = 1'b0;
        bit  in_st = 1'b0;
        st_t cur;
        cur = mk_st('0, '0, 0);
        timeout = 1'b0;
        halt_reqs = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (last_ret) rpc_q.push_back(pc);
            last_ret = retire;
            if (retire) ret_cyc.push_back(cyc);
            if (imem_req && imem_ready) fetch_q.push_back(imem_addr);
            if (dmem_req && dmem_we) begin
                if (!in_st) begin
                    cur = mk_st(dmem_addr, dmem_wdata, 0);
                    in_st = 1'b1;
                end
                cur.cnt++;
                if (dmem_addr !== cur.addr || dmem_wdata !== cur.data) cur.stable = 1'b0;
                if (dmem_ready) begin
                    act_q.push_back(cur);
                    in_st = 1'b0;
                end
            end
            if (halted) break;
            if (cyc >= budget) begin timeout = 1'b1; break; end
        end
        repeat (6) begin
            @(negedge clk);
            if (imem_req || dmem_req || retire) halt_reqs++;
        end
    endtask

    task automatic load_prog1();
        imem[0] = enc_i(6'd1, 1, 0, 5);
        imem[1] = enc_i(6'd1, 2, 0, -3);
        imem[2] = enc_r(3, 1, 2, 1);
        imem[3] = enc_i(6'd3, 3, 0, 32'h40);
    endtask

    task automatic test_reset();
        int n = 0;
        st_t e, a;
        clear_mem(); load_prog1();
        iwait = 2; dwait = 0;
        exp_q.delete(); exp_q.push_back(mk_st(16'h40, 32'd8, 1));
        do_reset();
        while (!(imem_req && imem_addr == 16'd4) && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL rst_reach_fetch4 got timeout want fetch of 0x4"); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({imem_req, dmem_req, dmem_we, retire, halted, illegal} !== 6'b0) begin
            errors++; $display("FAIL rst_outputs got %b want 000000", {imem_req, dmem_req, dmem_we, retire, halted, illegal});
        end
        checks++;
        if (pc !== 16'd0) begin errors++; $display("FAIL rst_pc got %h want 0000", pc); end
        iwait = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'd0 || pc !== 16'd0) begin
            errors++; $display("FAIL rst_refetch got req=%b addr=%h pc=%h want req=1 addr=0000 pc=0000", imem_req, imem_addr, pc);
        end
        run_prog(400);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act_q.size() == 0) begin errors++; $display("FAIL rst_store missing want addr=%h data=%h", e.addr, e.data); end
            else begin
                a = act_q.pop_front();
                if (a.addr !== e.addr || a.data !== e.data) begin
                    errors++; $display("FAIL rst_store got %h:%h want %h:%h", a.addr, a.data, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_alu();
        st_t e, a;
        clear_mem(); load_prog1();
        iwait = 0; dwait = 0;
        exp_q.delete(); exp_q.push_back(mk_st(16'h40, 32'd8, 1));
        do_reset();
        run_prog(300);
        checks++;
        if (timeout || ret_cyc.size() != 4) begin
            errors++; $display("FAIL alu_retires got %0d (timeout=%0d) want 4", ret_cyc.size(), timeout);
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (ret_cyc[i] - ret_cyc[i-1] !== 4) begin
                    errors++; $display("FAIL alu_latency[%0d] got %0d want 4", i, ret_cyc[i] - ret_cyc[i-1]);
                end
            end
            checks++;
            if (rpc_q[2] !== 16'd12) begin errors++; $display("FAIL alu_pc_after3 got %h want 000c", rpc_q[2]); end
        end
        checks++;
        if (halted !== 1'b1 || illegal !== 1'b0 || pc !== 16'h10 || halt_reqs !== 0) begin
            errors++; $display("FAIL alu_halt got h=%b i=%b pc=%h reqs=%0d want h=1 i=0 pc=0010 reqs=0", halted, illegal, pc, halt_reqs);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act_q.size() == 0) begin errors++; $display("FAIL alu_store missing want addr=%h data=%h", e.addr, e.data); end
            else begin
                a = act_q.pop_front();
                if (a.addr !== e.addr || a.data !== e.data || a.cnt !== e.cnt || !a.stable) begin
                    errors++; $display("FAIL alu_store got %h:%h cyc=%0d st=%0d want %h:%h cyc=%0d st=1", a.addr, a.data, a.cnt, a.stable, e.addr, e.data, e.cnt);
                end
            end
        end
    endtask

    task automatic test_mem();
        st_t e, a;
        int want [3] = '{7, 8, 7};
        clear_mem(); load_prog1();
        imem[4] = enc_i(6'd2, 4, 0, 32'h40);
        imem[5] = enc_i(6'd3, 4, 0, 32'h44);
        iwait = 0; dwait = 3;
        exp_q.delete();
        exp_q.push_back(mk_st(16'h40, 32'd8, 4));
        exp_q.push_back(mk_st(16'h44, 32'd8, 4));
        do_reset();
        run_prog(400);
        checks++;
        if (timeout || ret_cyc.size() != 6) begin
            errors++; $display("FAIL mem_retires got %0d (timeout=%0d) want 6", ret_cyc.size(), timeout);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ret_cyc[i+3] - ret_cyc[i+2] !== want[i]) begin
                    errors++; $display("FAIL mem_latency[%0d] got %0d want %0d", i, ret_cyc[i+3] - ret_cyc[i+2], want[i]);
                end
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act_q.size() == 0) begin errors++; $display("FAIL mem_store missing want addr=%h data=%h", e.addr, e.data); end
            else begin
                a = act_q.pop_front();
                if (a.addr !== e.addr || a.data !== e.data || a.cnt !== e.cnt || !a.stable) begin
                    errors++; $display("FAIL mem_store got %h:%h cyc=%0d st=%0d want %h:%h cyc=%0d st=1", a.addr, a.data, a.cnt, a.stable, e.addr, e.data, e.cnt);
                end
            end
        end
    endtask

    task automatic test_branch();
        int          cnd  [5] = '{1, 0, 2, 3, 2};
        int          rsel [5] = '{1, 1, 2, 0, 1};
        logic [15:0] tgt  [5] = '{16'h1C, 16'h24, 16'h1C, 16'h1C, 16'h24};
        for (int k = 0; k < 5; k++) begin
            clear_mem();
            imem[0] = enc_i(6'd1, 1, 0, 5);
            imem[1] = enc_i(6'd1, 2, 0, -3);
            imem[2] = {6'd5, 26'd5};
            imem[8] = enc_i(6'd4, cnd[k], rsel[k], -2);
            iwait = 0; dwait = 0;
            do_reset();
            run_prog(300);
            checks++;
            if (timeout || ret_cyc.size() != 4) begin
                errors++; $display("FAIL br%0d_retires got %0d want 4", k, ret_cyc.size());
            end else if (ret_cyc[2] - ret_cyc[1] !== 3 || ret_cyc[3] - ret_cyc[2] !== 3) begin
                errors++; $display("FAIL br%0d_latency got %0d,%0d want 3,3", k, ret_cyc[2] - ret_cyc[1], ret_cyc[3] - ret_cyc[2]);
            end
            checks++;
            if (pc !== tgt[k] || illegal !== 1'b0 || fetch_q.size() == 0 || fetch_q[fetch_q.size()-1] !== tgt[k]) begin
                errors++; $display("FAIL br%0d_target got pc=%h illegal=%b want pc=%h illegal=0", k, pc, illegal, tgt[k]);
            end
        end
    endtask

    task automatic test_misc();
        st_t e, a;
        clear_mem();
        imem[0]  = enc_i(6'd1, 0, 0, 7);
        imem[1]  = enc_r(5, 0, 0, 0);
        imem[2]  = enc_i(6'd3, 5, 0, 32'h50);
        imem[3]  = enc_i(6'd1, 1, 0, -1);
        imem[4]  = enc_i(6'd1, 2, 0, 1);
        imem[5]  = enc_r(6, 1, 2, 8);
        imem[6]  = enc_i(6'd3, 6, 0, 32'h54);
        imem[7]  = enc_i(6'd1, 7, 0, 1);
        imem[8]  = enc_i(6'd1, 8, 0, 31);
        imem[9]  = enc_r(7, 7, 8, 5);
        imem[10] = enc_i(6'd1, 9, 0, 4);
        imem[11] = enc_r(10, 7, 9, 7);
        imem[12] = enc_i(6'd3, 10, 0, 32'h58);
        imem[13] = enc_r(11, 7, 9, 6);
        imem[14] = enc_i(6'd3, 11, 0, 32'h5C);
        imem[15] = enc_r(12, 2, 1, 8);
        imem[16] = enc_i(6'd3, 12, 0, 32'h60);
        iwait = 1; dwait = 0;
        exp_q.delete();
        exp_q.push_back(mk_st(16'h50, 32'h0000_0000, 1));
        exp_q.push_back(mk_st(16'h54, 32'h0000_0001, 1));
        exp_q.push_back(mk_st(16'h58, 32'hF800_0000, 1));
        exp_q.push_back(mk_st(16'h5C, 32'h0800_0000, 1));
        exp_q.push_back(mk_st(16'h60, 32'h0000_0000, 1));
        do_reset();
        run_prog(800);
        checks++;
        if (timeout || ret_cyc.size() != 17 || ret_cyc[1] - ret_cyc[0] !== 5) begin
            errors++; $display("FAIL misc_retires got %0d (timeout=%0d) want 17 with ALU latency 5", ret_cyc.size(), timeout);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act_q.size() == 0) begin errors++; $display("FAIL misc_store missing want addr=%h data=%h", e.addr, e.data); end
            else begin
                a = act_q.pop_front();
                if (a.addr !== e.addr || a.data !== e.data || a.cnt !== e.cnt) begin
                    errors++; $display("FAIL misc_store got %h:%h cyc=%0d want %h:%h cyc=%0d", a.addr, a.data, a.cnt, e.addr, e.data, e.cnt);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] word [4];
        bit          ill  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        word[0] = {6'd7, 26'd0};
        word[1] = enc_r(3, 1, 2, 9);
        word[2] = enc_i(6'd4, 5, 1, 0);
        word[3] = HALT_W;
        for (int k = 0; k < 4; k++) begin
            clear_mem();
            for (int r = 0; r < 4; r++) imem[r] = enc_i(6'd1, r + 1, 0, r + 1);
            imem[4] = word[k];
            imem[5] = enc_i(6'd3, 1, 0, 32'h40);
            iwait = 0; dwait = 0;
            do_reset();
            run_prog(300);
            checks++;
            if (halted !== 1'b1 || illegal !== ill[k] || pc !== 16'h10) begin
                errors++; $display("FAIL ill%0d_state got h=%b i=%b pc=%h want h=1 i=%b pc=0010", k, halted, illegal, pc, ill[k]);
            end
            checks++;
            if (halt_reqs !== 0 || act_q.size() != 0 || ret_cyc.size() != 4) begin
                errors++; $display("FAIL ill%0d_quiet got reqs=%0d stores=%0d retires=%0d want 0,0,4", k, halt_reqs, act_q.size(), ret_cyc.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_misc();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the core stops making progress entirely.
    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kgp_multicycle_core.md
Name: kgp_multicycle_core

Overview:
- Parametrised multicycle KGP-RISC core: datapath plus integrated control FSM sequencing FETCH/DECODE/EXEC/MEM/WB.
- Generalised in data width, register count and address width.
- Instruction and data memories are external, behind req/ready handshakes that tolerate wait states.
- Sits at top level, between the instruction and data memory models.

Parameters:
- XLEN, 32: datapath/register width (>=16); instructions are always 32 bits.
- NREG, 32: register count (power of 2, <=32); r0 reads 0, writes ignored.
- ADDR_W, 16: byte-address width of PC and data address; arithmetic wraps mod 2^ADDR_W.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch byte address (= PC)
- imem_rdata  in  32  instruction word
- imem_ready  in  1  rdata valid; completes fetch
- dmem_req  out  1  data request
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_W  ALUOut[ADDR_W-1:0]
- dmem_wdata  out  XLEN  store data (B)
- dmem_rdata  in  XLEN  load data
- dmem_ready  in  1  completes data access
- pc  out  ADDR_W  current PC
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  sticky; core is in HALT
- illegal  out  1  sticky; halt was caused by an undefined opcode

Behaviour:
- Format: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[3:0], imm16[15:0], off26[25:0].
- Register indices use the low log2(NREG) bits.
- Immediates are sign-extended to XLEN. Branch/jump offsets are shifted left 2.
- Opcodes:
  - 0 R-ALU: rd = A op B (funct).
  - 1 I-ALU: rt = A op sext(imm16) (funct = op[?] none; uses imm16[15:12] as funct is NOT allowed; I-ALU is always ADD).
  - 2 LW: rt = mem[A + imm].
  - 3 SW: mem[A + imm] = B.
  - 4 BR: condition in rt field — 0 A==0, 1 A!=0, 2 A<0 signed, 3 always, others illegal; target = NPC + (imm16<<2).
  - 5 J: PC = NPC + (off26<<2).
  - 63 HALT.
  - Any other opcode is illegal.
- ALU funct: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra (shift amount = B[log2(XLEN)-1:0]), 8 slt signed (result 1/0). funct 9-15 is illegal.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: imem_req=1 held until the cycle imem_ready=1; on that edge IR <= rdata, NPC <= PC+4, go to DECODE.
  - DECODE: A, B <= regfile[rs], regfile[rt]; IMM <= sext. Illegal opcode/funct/cond -> HALT with illegal=1. HALT opcode -> HALT.
  - EXEC: ALUOut <= result.
    - BR/J: PC <= taken ? target : NPC, retire, -> FETCH.
    - LW/SW -> MEM. ALU -> WB.
  - MEM: dmem_req=1 (dmem_we=1 for SW), with addr/wdata stable until dmem_ready.
    - SW done: PC <= NPC, retire, -> FETCH.
    - LW done: LMD <= rdata, -> WB.
  - WB: write rd (R) or rt (I/LW); PC <= NPC; retire; -> FETCH.
  - HALT: absorbing. No requests, pc frozen at the HALT/illegal instruction address. Only reset exits.
- Zero-wait latency (cycles per instruction): ALU 4, LW 5, SW 4, branch/jump 3. Each ready wait cycle adds 1.
- ready asserted while req=0 is ignored. req never drops before ready. At most one of imem_req/dmem_req is high.
- Regfile: write on clk edge in WB only. Reads in DECODE see all prior writes.
- Reset (any time, including mid-handshake): immediately imem_req=dmem_req=dmem_we=0, retire=halted=illegal=0, PC=RESET_PC, state FETCH, IR/NPC/A/B/IMM/ALUOut/LMD=0, all registers 0. An in-flight access is abandoned; the core re-requests from RESET_PC after reset release.
- Wrap: PC+4 and targets wrap mod 2^ADDR_W. Add/sub wrap mod 2^XLEN; no overflow flag.

Test Plan:
- Reset with imem_req high mid-fetch -> req drops same cycle; after release, imem_addr=RESET_PC=0, pc=0, outputs 0.
- Program: I-ALU r1=r0+5, I-ALU r2=r0-3, R sub r3=r1-r2, zero-wait -> r3=8, retire every 4 cycles, pc=12.
- SW r3 to addr 0x40, then LW r4 from 0x40, dmem_ready delayed 3 cycles each -> dmem_we=1 held with addr 0x40, wdata 8 for 4 cycles; r4=8; LW takes 8 cycles.
- BR cond=1 on r1=5 with imm=-2 at PC 0x20 -> PC=0x1C. Cond=0 on same r1 -> PC=0x24. Branch completes in 3 cycles.
- Write to r0 then read r0 -> reads 0. slt of -1 vs 1 -> 1. sra of 0x80000000 by 4 -> 0xF8000000.
- Opcode 7 at PC 0x10 -> halted=1, illegal=1, pc=0x10, no further req. HALT opcode -> halted=1, illegal=0.
